// File: rtl/tinker_pkg.sv
// Shared Tinker ISA definitions: opcodes, instruction field positions and the literal type.
package tinker_pkg;

    localparam logic [4:0] OP_AND     = 5'h00;
    localparam logic [4:0] OP_OR      = 5'h01;
    localparam logic [4:0] OP_XOR     = 5'h02;
    localparam logic [4:0] OP_NOT     = 5'h03;
    localparam logic [4:0] OP_SHFTR   = 5'h04;
    localparam logic [4:0] OP_SHFTRI  = 5'h05;
    localparam logic [4:0] OP_SHFTL   = 5'h06;
    localparam logic [4:0] OP_SHFTLI  = 5'h07;
    localparam logic [4:0] OP_BR      = 5'h08;
    localparam logic [4:0] OP_BRR_R   = 5'h09;
    localparam logic [4:0] OP_BRR_L   = 5'h0A;
    localparam logic [4:0] OP_BRNZ    = 5'h0B;
    localparam logic [4:0] OP_CALL    = 5'h0C;
    localparam logic [4:0] OP_RETURN  = 5'h0D;
    localparam logic [4:0] OP_BRGT    = 5'h0E;
    localparam logic [4:0] OP_PRIV    = 5'h0F;
    localparam logic [4:0] OP_MOV_MR  = 5'h10;
    localparam logic [4:0] OP_MOV_RR  = 5'h11;
    localparam logic [4:0] OP_MOV_RL  = 5'h12;
    localparam logic [4:0] OP_MOV_RM  = 5'h13;
    localparam logic [4:0] OP_ADDF    = 5'h14;
    localparam logic [4:0] OP_SUBF    = 5'h15;
    localparam logic [4:0] OP_MULF    = 5'h16;
    localparam logic [4:0] OP_DIVF    = 5'h17;
    localparam logic [4:0] OP_ADD     = 5'h18;
    localparam logic [4:0] OP_ADDI    = 5'h19;
    localparam logic [4:0] OP_SUB     = 5'h1A;
    localparam logic [4:0] OP_SUBI    = 5'h1B;
    localparam logic [4:0] OP_MUL     = 5'h1C;
    localparam logic [4:0] OP_DIV     = 5'h1D;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned RD_MSB     = 26;
    localparam int unsigned RD_LSB     = 22;
    localparam int unsigned RS_MSB     = 21;
    localparam int unsigned RS_LSB     = 17;
    localparam int unsigned RT_MSB     = 16;
    localparam int unsigned RT_LSB     = 12;
    localparam int unsigned LIT_MSB    = 11;
    localparam int unsigned LIT_LSB    = 0;

    typedef logic [63:0] literal_t;

    // Register-immediate forms read and write the same register, so rs is taken from rd.
    function automatic logic is_reg_imm(input logic [4:0] op);
        case (op)
            OP_SHFTRI, OP_SHFTLI, OP_MOV_RL, OP_ADDI, OP_SUBI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_fields.sv
// Combinational field slicer: splits an instruction word, substitutes rs and extends the literal.
module instruction_fields
    import tinker_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_opcode,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output literal_t    o_literal
);

    logic [4:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs_raw;

    assign w_opcode  = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign w_rd      = i_instr[RD_MSB:RD_LSB];
    assign w_rs_raw  = i_instr[RS_MSB:RS_LSB];

    assign o_opcode  = w_opcode;
    assign o_rd      = w_rd;
    assign o_rs      = is_reg_imm(w_opcode) ? w_rd : w_rs_raw;
    assign o_rt      = i_instr[RT_MSB:RT_LSB];
    // Zero-extended; branch consumers sign-extend bit 11 themselves.
    assign o_literal = literal_t'(i_instr[LIT_MSB:LIT_LSB]);

endmodule

// File: rtl/instruction_decoder.sv
// Registered Tinker instruction decoder: combinational field slice followed by one output stage.
module instruction_decoder
    import tinker_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instructionLine,
    output logic        dec_valid,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output literal_t    literal
);

    logic [4:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    literal_t   w_literal;

    logic       r_valid;
    logic [4:0] r_opcode;
    logic [4:0] r_rd;
    logic [4:0] r_rs;
    logic [4:0] r_rt;
    literal_t   r_literal;

    instruction_fields u_fields (
        .i_instr   (instructionLine),
        .o_opcode  (w_opcode),
        .o_rd      (w_rd),
        .o_rs      (w_rs),
        .o_rt      (w_rt),
        .o_literal (w_literal)
    );

    // Fields load only on a valid word and otherwise hold the last decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_opcode  <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_literal <= '0;
        end else begin
            r_valid <= instr_valid;
            if (instr_valid) begin
                r_opcode  <= w_opcode;
                r_rd      <= w_rd;
                r_rs      <= w_rs;
                r_rt      <= w_rt;
                r_literal <= w_literal;
            end
        end
    end

    assign dec_valid = r_valid;
    assign opcode    = r_opcode;
    assign rd        = r_rd;
    assign rs        = r_rs;
    assign rt        = r_rt;
    assign literal   = r_literal;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: directed plan words plus randomized traffic.
module tb_instruction_decoder;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [63:0] literal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instructionLine;
    logic        dec_valid;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [63:0] literal;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t last_exp = '0;

    instruction_decoder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instructionLine (instructionLine),
        .dec_valid       (dec_valid),
        .opcode          (opcode),
        .rd              (rd),
        .rs              (rs),
        .rt              (rt),
        .literal         (literal)
    );

    always #5 clk = ~clk;

    // Reference model: plain shifts and a membership list of the rd-as-source opcodes.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int unsigned u;
        int unsigned reg_imm [5] = '{5, 7, 18, 25, 27};
        bit sub;
        u = w;
        e.opcode  = 5'((u >> 27) % 32);
        e.rd      = 5'((u >> 22) % 32);
        e.rt      = 5'((u >> 12) % 32);
        e.literal = 64'(u % 4096);
        sub = 1'b0;
        foreach (reg_imm[i]) if ((u >> 27) == reg_imm[i]) sub = 1'b1;
        e.rs = sub ? e.rd : 5'((u >> 17) % 32);
        return e;
    endfunction

    function automatic exp_t current();
        return '{opcode: opcode, rd: rd, rs: rs, rt: rt, literal: literal};
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got op=%h rd=%h rs=%h rt=%h lit=%h, want op=%h rd=%h rs=%h rt=%h lit=%h",
                     name, act.opcode, act.rd, act.rs, act.rt, act.literal,
                     exp.opcode, exp.rd, exp.rs, exp.rt, exp.literal);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic issue_exp(input logic [31:0] w, input exp_t e);
        @(negedge clk);
        instr_valid     = 1'b1;
        instructionLine = w;
        q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] w);
        issue_exp(w, model(w));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid     = 1'b0;
            instructionLine = $urandom;
        end
    endtask

    // Monitor: one check per cycle, just after the capturing edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                chk_int("reset_valid", int'(dec_valid), 0);
                chk("reset_fields", current(), '0);
            end else if (dec_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got dec_valid=1, want no pending word");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("decode", current(), e);
                    last_exp = e;
                end
            end else begin
                chk("hold", current(), last_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ri_ops [4] = '{5'h05, 5'h07, 5'h12, 5'h1B};
        logic [31:0] w;

        reset_n         = 1'b0;
        instr_valid     = 1'b1;
        instructionLine = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        instr_valid = 1'b0;
        reset_n     = 1'b1;

        issue_exp({5'b01011, 5'b11010, 5'b10101, 5'b01010, 12'b000001011111},
                  '{opcode: 5'b01011, rd: 5'b11010, rs: 5'b10101, rt: 5'b01010, literal: 64'h05F});
        issue_exp({5'b10101, 5'b11110, 5'b00110, 5'b00000, 12'b000101110101},
                  '{opcode: 5'b10101, rd: 5'b11110, rs: 5'b00110, rt: 5'b00000, literal: 64'h175});
        issue_exp({5'b11001, 5'b00010, 5'b00000, 5'b00000, 12'b000000000110},
                  '{opcode: 5'b11001, rd: 5'b00010, rs: 5'b00010, rt: 5'b00000, literal: 64'h006});
        foreach (ri_ops[i])
            issue_exp({ri_ops[i], 5'b10011, 5'b00111, 5'b01100, 12'h0A5},
                      '{opcode: ri_ops[i], rd: 5'b10011, rs: 5'b10011, rt: 5'b01100,
                        literal: 64'h0A5});
        issue_exp({5'h0A, 5'b00001, 5'b00010, 5'b00011, 12'hFFF},
                  '{opcode: 5'h0A, rd: 5'b00001, rs: 5'b00010, rt: 5'b00011,
                    literal: 64'h0000_0000_0000_0FFF});

        idle(3);
        for (int i = 0; i < 6; i++) issue($urandom);

        // Asynchronous reset between clock edges with a word in flight.
        issue(32'hFFFF_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk_int("async_clear_valid", int'(dec_valid), 0);
        chk("async_clear_fields", current(), '0);
        q.delete();
        last_exp    = '0;
        instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                w = $urandom;
                if ($urandom_range(0, 2) == 0) w[31:27] = ri_ops[$urandom_range(0, 3)];
                issue(w);
            end
        end

        idle(3);
        chk_int("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
